clock_set_ctrl: RTL and testbench

Time-setting controller for the digital clock datapath. It sequences the second, minute and hour counters:
- In RUN it forwards the 1 Hz tick as the seconds-increment.
- In the set modes it freezes timekeeping and turns mode/increment button presses, including auto-repeat, into single-cycle increment pulses on the selected counter.
- It also drives a blink enable for the display and a seconds-clear when setting ends.

---
 rtl/clock_pkg.sv | 27 ++
 rtl/btn_sync_edge.sv | 30 +++
 rtl/clock_set_ctrl.sv | 169 ++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared encodings and build constants for the clock time-setting controller.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_e;

    localparam int SIM_HOLD_CYCLES     = 16;
    localparam int SIM_REPEAT_CYCLES   = 4;
    localparam int SIM_TIMEOUT_TICKS   = 10;
    localparam int BOARD_HOLD_CYCLES   = 25_000_000;
    localparam int BOARD_REPEAT_CYCLES = 5_000_000;
    localparam int BOARD_TIMEOUT_TICKS = 10;
    localparam int DEFAULT_CNT_W       = 26;

    // Mode-button sequence RUN -> SET_HOUR -> SET_MIN -> RUN.
    function automatic mode_e next_mode(input mode_e cur);
        case (cur)
            MODE_RUN:      return MODE_SET_HOUR;
            MODE_SET_HOUR: return MODE_SET_MIN;
            default:       return MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button level plus a rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Combinational edge so the registered controller outputs land 3 edges after the button moves.
    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: RUN/SET_HOUR/SET_MIN sequencing, auto-repeat, timeout and blink.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int HOLD_CYCLES   = SIM_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = SIM_REPEAT_CYCLES,
    parameter int TIMEOUT_TICKS = SIM_TIMEOUT_TICKS,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       hour_inc,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

    logic mode_lvl_unused;
    logic mode_rise;
    logic inc_lvl;
    logic inc_rise;

    btn_sync_edge u_mode_sync (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_mode),
        .level_o (mode_lvl_unused),
        .rise_o  (mode_rise)
    );

    btn_sync_edge u_inc_sync (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_inc),
        .level_o (inc_lvl),
        .rise_o  (inc_rise)
    );

    mode_e            state_q, state_d;
    logic             sec_inc_q, sec_inc_d;
    logic             min_inc_q, min_inc_d;
    logic             hour_inc_q, hour_inc_d;
    logic             sec_clr_q, sec_clr_d;
    logic             blink_q, blink_d;
    logic             ph_q, ph_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d;
    logic             arm_q, arm_d;
    logic [TO_W-1:0]  to_q, to_d;

    logic             in_set;
    logic             timeout_hit;
    logic             leaving;
    logic             inc_pulse;
    logic [CNT_W-1:0] limit;

    assign in_set      = (state_q == MODE_SET_HOUR) || (state_q == MODE_SET_MIN);
    assign timeout_hit = in_set && tick_1hz && (to_q == TO_W'(TIMEOUT_TICKS - 1));
    assign limit       = rep_q ? CNT_W'(REPEAT_CYCLES - 1) : CNT_W'(HOLD_CYCLES - 1);

    always_comb begin
        state_d    = state_q;
        sec_inc_d  = 1'b0;
        min_inc_d  = 1'b0;
        hour_inc_d = 1'b0;
        sec_clr_d  = 1'b0;
        cnt_d      = cnt_q;
        rep_d      = rep_q;
        arm_d      = arm_q;
        to_d       = to_q;
        ph_d       = ph_q;
        inc_pulse  = 1'b0;
        leaving    = 1'b0;

        // Timeout outranks a coincident mode edge so both collapse into one exit to RUN.
        case (state_q)
            MODE_RUN: begin
                sec_inc_d = tick_1hz;
                if (mode_rise) state_d = MODE_SET_HOUR;
            end
            MODE_SET_HOUR, MODE_SET_MIN: begin
                if (timeout_hit) begin
                    state_d   = MODE_RUN;
                    sec_clr_d = 1'b1;
                end else if (mode_rise) begin
                    state_d   = next_mode(state_q);
                    sec_clr_d = (state_q == MODE_SET_MIN);
                end
            end
            default: state_d = MODE_RUN;
        endcase

        leaving = (state_d != state_q);

        // Repeat only runs after an initial pulse in this mode; a mode change disarms it.
        if (!in_set || leaving || !inc_lvl) begin
            cnt_d = '0;
            rep_d = 1'b0;
            arm_d = 1'b0;
        end else if (inc_rise) begin
            inc_pulse = 1'b1;
            cnt_d     = '0;
            rep_d     = 1'b0;
            arm_d     = 1'b1;
        end else if (arm_q) begin
            if (cnt_q == limit) begin
                inc_pulse = 1'b1;
                cnt_d     = '0;
                rep_d     = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        hour_inc_d = inc_pulse && (state_q == MODE_SET_HOUR);
        min_inc_d  = inc_pulse && (state_q == MODE_SET_MIN);

        if (!in_set || leaving || mode_rise || inc_rise) to_d = '0;
        else if (tick_1hz)                             to_d = to_q + 1'b1;

        if (!in_set || leaving) ph_d = 1'b0;
        else if (tick_1hz)      ph_d = ~ph_q;

        blink_d = ph_d & ~inc_pulse;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= MODE_RUN;
            sec_inc_q  <= 1'b0;
            min_inc_q  <= 1'b0;
            hour_inc_q <= 1'b0;
            sec_clr_q  <= 1'b0;
            blink_q    <= 1'b0;
            ph_q       <= 1'b0;
            cnt_q      <= '0;
            rep_q      <= 1'b0;
            arm_q      <= 1'b0;
            to_q       <= '0;
        end else begin
            state_q    <= state_d;
            sec_inc_q  <= sec_inc_d;
            min_inc_q  <= min_inc_d;
            hour_inc_q <= hour_inc_d;
            sec_clr_q  <= sec_clr_d;
            blink_q    <= blink_d;
            ph_q       <= ph_d;
            cnt_q      <= cnt_d;
            rep_q      <= rep_d;
            arm_q      <= arm_d;
            to_q       <= to_d;
        end
    end

    assign sec_inc  = sec_inc_q;
    assign min_inc  = min_inc_q;
    assign hour_inc = hour_inc_q;
    assign sec_clr  = sec_clr_q;
    assign blink    = blink_q;
    assign mode     = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with hand-computed expectations (HOLD=16, REPEAT=4, TIMEOUT=10).
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic       sec_inc;
    logic       min_inc;
    logic       hour_inc;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blink;

    clock_set_ctrl #(
        .HOLD_CYCLES   (16),
        .REPEAT_CYCLES (4),
        .TIMEOUT_TICKS (10),
        .CNT_W         (26)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_inc  (sec_inc),
        .min_inc  (min_inc),
        .hour_inc (hour_inc),
        .sec_clr  (sec_clr),
        .mode     (mode),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int sec_n, min_n, hour_n, clr_n, blink_n;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    // One clock: sample outputs 1 time unit after the rising edge and log pulses.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (sec_inc)  sec_n++;
        if (min_inc)  begin min_n++; obs_q.push_back(cyc); end
        if (hour_inc) hour_n++;
        if (sec_clr)  clr_n++;
        if (blink)    blink_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_counts();
        sec_n = 0; min_n = 0; hour_n = 0; clr_n = 0; blink_n = 0;
        obs_q.delete();
    endtask

    // Two-cycle press; returns right after the edge-caused output becomes visible.
    task automatic press(input bit is_mode);
        if (is_mode) btn_mode = 1'b1; else btn_inc = 1'b1;
        step();
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step();
    endtask

    task automatic tick_once();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check("rst_mode", mode, 0);
        check("rst_pulses", {sec_inc, min_inc, hour_inc, sec_clr}, 0);
        check("rst_blink", blink, 0);
        rst = 1'b1;
        idle(2);

        // 1: RUN forwards ticks one cycle late
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            tick_once();
            check("t1_sec_inc_on", sec_inc, 1);
            step();
            check("t1_sec_inc_off", sec_inc, 0);
            idle(1);
        end
        check("t1_mode", mode, 0);
        check("t1_sec_count", sec_n, 5);
        check("t1_other_pulses", min_n + hour_n + clr_n + blink_n, 0);

        // 2: SET_HOUR increments and blink
        clear_counts();
        press(1'b1);
        check("t2_mode", mode, 1);
        check("t2_blink_entry", blink, 0);
        idle(2);
        tick_once();
        check("t2_blink_tick1", blink, 1);
        idle(1);
        press(1'b0);
        check("t2_hour_pulse", hour_inc, 1);
        check("t2_blink_forced", blink, 0);
        step();
        check("t2_hour_single", hour_inc, 0);
        check("t2_blink_restore", blink, 1);
        idle(2);
        tick_once();
        check("t2_blink_tick2", blink, 0);
        idle(2);
        press(1'b0);
        idle(3);
        press(1'b0);
        idle(3);
        tick_once();
        check("t2_blink_tick3", blink, 1);
        idle(2);
        check("t2_hour_count", hour_n, 3);
        check("t2_sec_frozen", sec_n, 0);
        check("t2_min_clr", min_n + clr_n, 0);

        // 3: SET_MIN auto-repeat while held 30 cycles
        press(1'b1);
        check("t3_mode", mode, 2);
        idle(2);
        clear_counts();
        exp_q.delete();
        exp_q.push_back(0); exp_q.push_back(16); exp_q.push_back(20);
        exp_q.push_back(24); exp_q.push_back(28);
        btn_inc = 1'b1;
        idle(30);
        btn_inc = 1'b0;
        idle(5);
        check("t3_min_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) check($sformatf("t3_offset%0d", i), obs_q[i] - obs_q[0], exp_q[i]);
        end
        check("t3_hour_none", hour_n, 0);
        check("t3_mode_kept", mode, 2);

        // 4: exit from SET_MIN with a coincident tick
        clear_counts();
        btn_mode = 1'b1;
        step();
        step();
        btn_mode = 1'b0;
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check("t4_mode", mode, 0);
        check("t4_sec_clr", sec_clr, 1);
        check("t4_sec_inc_masked", sec_inc, 0);
        step();
        check("t4_clr_single", sec_clr, 0);
        idle(2);
        tick_once();
        check("t4_sec_inc_next", sec_inc, 1);
        idle(2);

        // 5: timeout after 10 idle ticks, restarted by an inc edge
        press(1'b1);
        check("t5a_mode", mode, 1);
        idle(2);
        clear_counts();
        for (int i = 1; i <= 10; i++) begin
            tick_once();
            if (i == 9)  check("t5a_before", mode, 1);
            if (i == 10) begin
                check("t5a_exit_mode", mode, 0);
                check("t5a_exit_clr", sec_clr, 1);
            end
            idle(2);
        end
        check("t5a_clr_count", clr_n, 1);
        press(1'b1);
        idle(2);
        for (int i = 0; i < 9; i++) begin
            tick_once();
            idle(2);
        end
        press(1'b0);
        check("t5b_hour_pulse", hour_inc, 1);
        idle(2);
        clear_counts();
        for (int i = 1; i <= 10; i++) begin
            tick_once();
            if (i == 9)  check("t5b_before", mode, 1);
            if (i == 10) begin
                check("t5b_exit_mode", mode, 0);
                check("t5b_exit_clr", sec_clr, 1);
            end
            idle(2);
        end
        check("t5b_clr_count", clr_n, 1);

        // 6: reset mid-repeat, then simultaneous mode+inc edges
        press(1'b1);
        idle(2);
        press(1'b1);
        check("t6_mode_setmin", mode, 2);
        idle(2);
        btn_inc = 1'b1;
        idle(22);
        #2;
        rst = 1'b0;
        btn_inc = 1'b0;
        #1;
        check("t6_rst_mode", mode, 0);
        check("t6_rst_pulses", {sec_inc, min_inc, hour_inc, sec_clr, blink}, 0);
        step();
        step();
        rst = 1'b1;
        clear_counts();
        step();
        check("t6_release_mode", mode, 0);
        check("t6_release_pulses", {sec_inc, min_inc, hour_inc, sec_clr, blink}, 0);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step();
        step();
        btn_mode = 1'b0;
        step();
        check("t6_mode_wins", mode, 1);
        check("t6_no_hour", hour_inc, 0);
        idle(4);
        btn_inc = 1'b0;
        idle(3);
        check("t6_hour_count", hour_n, 0);
        check("t6_min_count", min_n, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
